// File: rtl/cv32e41p_pkg.sv
// Shared constants for the cv32e41p fetch path.
package cv32e41p_pkg;

  localparam int unsigned FetchFifoDepth      = 2;
  localparam int unsigned FetchMaxOutstanding = 2;

endpackage

// File: rtl/cv32e41p_fetch_fifo.sv
// Word-wide instruction buffer between instruction memory and the aligner, with
// same-cycle bypass when empty and discard of responses that belong to a flushed stream.
module cv32e41p_fetch_fifo
  import cv32e41p_pkg::*;
#(
  parameter int unsigned DEPTH           = FetchFifoDepth,
  parameter int unsigned MAX_OUTSTANDING = FetchMaxOutstanding
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trans_issued_i,
  input  logic                       resp_valid_i,
  input  logic [31:0]                resp_rdata_i,
  input  logic                       flush_i,
  output logic                       fetch_valid_o,
  output logic [31:0]                fetch_rdata_o,
  input  logic                       fetch_ready_i,
  output logic                       req_allowed_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OstW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [OstW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic            empty, accept, push, pop;
  logic [31:0]     occupancy;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    empty  = (cnt_q == '0);
    accept = resp_valid_i & (drop_q == '0) & ~flush_i;

    fetch_valid_o = ~flush_i & (~empty | accept);
    if (!empty) begin
      fetch_rdata_o = mem_q[rptr_q];
    end else if (accept) begin
      fetch_rdata_o = resp_rdata_i;
    end else begin
      fetch_rdata_o = '0;
    end

    // A bypassed word consumed in the same cycle never touches storage.
    pop  = fetch_valid_o & fetch_ready_i & ~empty;
    push = accept & ~(empty & fetch_ready_i);

    // Live words plus live in-flight responses; pending drops will never land.
    occupancy     = 32'(cnt_q) + 32'(outst_q) - 32'(drop_q);
    req_allowed_o = (32'(outst_q) < MAX_OUTSTANDING) & (occupancy < DEPTH);
    cnt_o         = cnt_q;
  end

  always_comb begin
    outst_d = outst_q + OstW'(trans_issued_i) - OstW'(resp_valid_i);
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    if (flush_i) begin
      // Every transaction issued before this cycle and not answered now is dead.
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      drop_d = outst_q - OstW'(resp_valid_i);
    end else begin
      if (resp_valid_i && (drop_q != '0)) begin
        drop_d = drop_q - OstW'(1);
      end
      if (push) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= resp_rdata_i;
    end
  end

`ifdef CV32E41P_ASSERT_ON
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (cnt_q == CntW'(DEPTH)) && !pop));
  a_no_outst_underflow: assert property (@(posedge clk) disable iff (rst)
    !(resp_valid_i && (outst_q == '0)));
  a_no_drop_underflow: assert property (@(posedge clk) disable iff (rst)
    drop_q <= outst_q);
  a_no_valid_on_flush: assert property (@(posedge clk) disable iff (rst)
    !(flush_i && fetch_valid_o));
`endif

endmodule

// File: tb/tb_cv32e41p_fetch_fifo.sv
// Bench for cv32e41p_fetch_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cv32e41p_fetch_fifo;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        trans_issued;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_rdata;
  logic        fetch_ready;
  logic        req_allowed;
  logic [1:0]  cnt;

  int checks   = 0;
  int failures = 0;

  cv32e41p_fetch_fifo #(
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trans_issued_i(trans_issued),
    .resp_valid_i  (resp_valid),
    .resp_rdata_i  (resp_rdata),
    .flush_i       (flush),
    .fetch_valid_o (fetch_valid),
    .fetch_rdata_o (fetch_rdata),
    .fetch_ready_i (fetch_ready),
    .req_allowed_o (req_allowed),
    .cnt_o         (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered words in a queue, plus counts of live and doomed responses.
  logic [31:0] m_q[$];
  int          m_outst = 0;
  int          m_drop  = 0;
  bit          m_ok    = 0;

  always @(negedge clk) begin
    bit          acc;
    bit          e_valid;
    logic [31:0] e_rdata;
    bit          e_req;
    acc     = resp_valid && (m_drop == 0) && !flush;
    e_valid = !flush && ((m_q.size() > 0) || acc);
    e_rdata = (m_q.size() > 0) ? m_q[0] : (acc ? resp_rdata : 32'h0);
    e_req   = (m_outst < MAXO) && (m_q.size() + m_outst - m_drop < DEPTH);
    if (m_ok) begin
      check("model_valid", {31'b0, fetch_valid}, {31'b0, e_valid});
      if (e_valid || m_q.size() == 0)
        check("model_rdata", fetch_rdata, e_rdata);
      check("model_req", {31'b0, req_allowed}, {31'b0, e_req});
      check("model_cnt", {30'b0, cnt}, m_q.size());
    end
    if (rst) begin
      m_q.delete();
      m_outst = 0;
      m_drop  = 0;
      m_ok    = 1;
    end else if (m_ok) begin
      if (flush) begin
        m_q.delete();
        m_drop = m_outst - int'(resp_valid);
      end else begin
        if (resp_valid && m_drop > 0) m_drop--;
        if (acc) m_q.push_back(resp_rdata);
        if (e_valid && fetch_ready) void'(m_q.pop_front());
      end
      m_outst = m_outst + int'(trans_issued) - int'(resp_valid);
    end
  end

  // One cycle of stimulus; returns mid-cycle so combinational outputs can be checked.
  task automatic drive(input logic iss, input logic rv, input logic [31:0] d,
                       input logic fl, input logic rdy);
    @(posedge clk);
    #1;
    trans_issued = iss;
    resp_valid   = rv;
    resp_rdata   = d;
    flush        = fl;
    fetch_ready  = rdy;
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, fetch_valid}, 32'h0);
    check({tag, "_rdata"}, fetch_rdata, 32'h0);
    check({tag, "_req"}, {31'b0, req_allowed}, 32'h1);
    check({tag, "_cnt"}, {30'b0, cnt}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    trans_issued = 0; resp_valid = 0; resp_rdata = 0; flush = 0; fetch_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2 check_reset_outputs("reset");

    // Bypass
    drive(1, 0, 32'h0, 0, 0);
    check("t1_req", {31'b0, req_allowed}, 32'h1);
    drive(0, 1, 32'h00000013, 0, 1);
    check("t1_valid", {31'b0, fetch_valid}, 32'h1);
    check("t1_rdata", fetch_rdata, 32'h00000013);
    check("t1_cnt", {30'b0, cnt}, 32'h0);
    drive(0, 0, 32'h0, 0, 0);
    check("t1_cnt_after", {30'b0, cnt}, 32'h0);

    // Fill and throttle
    drive(1, 0, 32'h0, 0, 0);
    drive(1, 0, 32'h0, 0, 0);
    check("t2_req_one_out", {31'b0, req_allowed}, 32'h1);
    drive(0, 1, 32'hAAAA0001, 0, 0);
    check("t2_req_two_out", {31'b0, req_allowed}, 32'h0);
    check("t2_bypass_rdata", fetch_rdata, 32'hAAAA0001);
    drive(0, 1, 32'hAAAA0002, 0, 0);
    check("t2_head_rdata", fetch_rdata, 32'hAAAA0001);
    check("t2_req_mid", {31'b0, req_allowed}, 32'h0);
    drive(0, 0, 32'h0, 0, 1);
    check("t2_full_cnt", {30'b0, cnt}, 32'h2);
    check("t2_full_req", {31'b0, req_allowed}, 32'h0);
    check("t2_pop1", fetch_rdata, 32'hAAAA0001);
    drive(0, 0, 32'h0, 0, 1);
    check("t2_req_back", {31'b0, req_allowed}, 32'h1);
    check("t2_pop2", fetch_rdata, 32'hAAAA0002);
    drive(0, 0, 32'h0, 0, 0);
    check("t2_empty", {30'b0, cnt}, 32'h0);

    // Flush with two outstanding
    drive(1, 0, 32'h0, 0, 0);
    drive(1, 0, 32'h0, 0, 0);
    drive(0, 0, 32'h0, 1, 1);
    check("t3_flush_valid", {31'b0, fetch_valid}, 32'h0);
    drive(0, 1, 32'hDEAD0000, 0, 1);
    check("t3_drop0", {31'b0, fetch_valid}, 32'h0);
    drive(1, 1, 32'hDEAD0001, 0, 1);
    check("t3_drop1", {31'b0, fetch_valid}, 32'h0);
    check("t3_req", {31'b0, req_allowed}, 32'h1);
    drive(0, 1, 32'h12345678, 0, 0);
    check("t3_new_valid", {31'b0, fetch_valid}, 32'h1);
    check("t3_new_rdata", fetch_rdata, 32'h12345678);
    drive(0, 0, 32'h0, 0, 1);
    check("t3_held_rdata", fetch_rdata, 32'h12345678);
    drive(0, 0, 32'h0, 0, 0);
    check("t3_empty", {30'b0, cnt}, 32'h0);

    // Flush coinciding with the last response
    drive(1, 0, 32'h0, 0, 0);
    drive(0, 1, 32'hBAD0BAD0, 1, 1);
    check("t4_flush_valid", {31'b0, fetch_valid}, 32'h0);
    drive(1, 0, 32'h0, 0, 0);
    check("t4_cnt", {30'b0, cnt}, 32'h0);
    check("t4_req", {31'b0, req_allowed}, 32'h1);
    drive(0, 1, 32'h00000055, 0, 1);
    check("t4_not_dropped", {31'b0, fetch_valid}, 32'h1);
    check("t4_rdata", fetch_rdata, 32'h00000055);

    // Pop and push together at full
    drive(1, 0, 32'h0, 0, 0);
    drive(1, 0, 32'h0, 0, 0);
    drive(0, 1, 32'h00000011, 0, 0);
    drive(0, 1, 32'h00000022, 0, 0);
    drive(1, 0, 32'h0, 0, 0);
    check("t5_full", {30'b0, cnt}, 32'h2);
    drive(0, 1, 32'h00000033, 0, 1);
    check("t5_pp_rdata", fetch_rdata, 32'h00000011);
    check("t5_pp_cnt", {30'b0, cnt}, 32'h2);
    drive(0, 0, 32'h0, 0, 1);
    check("t5_after_cnt", {30'b0, cnt}, 32'h2);
    check("t5_order2", fetch_rdata, 32'h00000022);
    drive(0, 0, 32'h0, 0, 1);
    check("t5_order3", fetch_rdata, 32'h00000033);
    drive(0, 0, 32'h0, 0, 0);
    check("t5_empty", {30'b0, cnt}, 32'h0);

    // Reset mid-stream
    drive(1, 0, 32'h0, 0, 0);
    drive(0, 1, 32'h00000044, 0, 0);
    drive(1, 0, 32'h0, 0, 0);
    check("t6_cnt_before", {30'b0, cnt}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    trans_issued = 0; resp_valid = 0; flush = 0; fetch_ready = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    #2 check_reset_outputs("t6");

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
